rv32_lsu: RTL

RV32_LSU -- requirements
Module: rv32_lsu

---
 rtl/rv32_lsu_if.sv | 31 +++
 rtl/rv32_lsu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_lsu_if.sv
// Core-side and memory-side signal bundle for the rv32_lsu load/store unit.
// The slave modport is the LSU's view; the master modport is the core/memory side.
interface rv32_lsu_if #(
    parameter int AW = 32
) ();
    logic [AW-1:0] address;
    logic          MemRead;
    logic          MemWrite;
    logic [2:0]    funct3;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          stall;
    logic          bus_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ack;

    modport slave (
        input  address, MemRead, MemWrite, funct3, wdata, mem_rdata, mem_ack,
        output rdata, stall, bus_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output address, MemRead, MemWrite, funct3, wdata, mem_rdata, mem_ack,
        input  rdata, stall, bus_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/rv32_lsu.sv
// RV32 load/store unit: IDLE/REQ/RESP sequencer with lane steering, load extension and ack timeout.
// Optional macro RV32_LSU_MISALIGN_CHECK_EN rejects misaligned H/W accesses with bus_err instead of force-aligning.
module rv32_lsu #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    rv32_lsu_if.slave    bus
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_wait_cnt;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [3:0]    r_mem_be;
    logic [31:0]   r_mem_wdata;
    logic [31:0]   r_rdata;
    logic          r_bus_err;
    logic [1:0]    r_off;
    logic [1:0]    r_size;
    logic          r_unsigned;

    logic          w_req_in;
    logic [1:0]    w_size;
    logic [1:0]    w_off;
    logic          w_misalign;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic          w_timeout;
    logic          w_accept;
    logic          w_fault;
    logic          w_done;
    logic          w_stall;
    logic [7:0]    w_lane8;
    logic [15:0]   w_lane16;
    logic [31:0]   w_load;

    assign w_req_in  = bus.MemRead | bus.MemWrite;
    assign w_timeout = (r_state == ST_REQ) && !bus.mem_ack && (r_wait_cnt == CW'(TIMEOUT - 1));

    // Request decode: size (unsupported codes fall to word), lane offset, byte enables, store data.
    always_comb begin
        w_size = 2'd2;
        case (bus.funct3[1:0])
            2'b00:   w_size = 2'd0;
            2'b01:   w_size = 2'd1;
            default: w_size = 2'd2;
        endcase

        w_off = 2'b00;
        case (w_size)
            2'd0:    w_off = bus.address[1:0];
            2'd1:    w_off = {bus.address[1], 1'b0};
            default: w_off = 2'b00;
        endcase

`ifdef RV32_LSU_MISALIGN_CHECK_EN
        w_misalign = ((w_size == 2'd1) && bus.address[0]) ||
                     ((w_size == 2'd2) && (bus.address[1:0] != 2'b00));
`else
        w_misalign = 1'b0;
`endif

        w_be    = 4'b1111;
        w_wdata = 32'h0000_0000;
        if (bus.MemWrite) begin
            case (w_size)
                2'd0: begin
                    w_be    = 4'b0001 << w_off;
                    w_wdata = {4{bus.wdata[7:0]}};
                end
                2'd1: begin
                    w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{bus.wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = bus.wdata;
                end
            endcase
        end else begin
            w_be    = 4'b1111;
            w_wdata = 32'h0000_0000;
        end
    end

    // Load lane selection and sign/zero extension of the returned word.
    always_comb begin
        w_lane8 = 8'h00;
        case (r_off)
            2'b00:   w_lane8 = bus.mem_rdata[7:0];
            2'b01:   w_lane8 = bus.mem_rdata[15:8];
            2'b10:   w_lane8 = bus.mem_rdata[23:16];
            2'b11:   w_lane8 = bus.mem_rdata[31:24];
            default: w_lane8 = 8'h00;
        endcase
        w_lane16 = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

        w_load = bus.mem_rdata;
        case (r_size)
            2'd0:    w_load = r_unsigned ? {24'h00_0000, w_lane8} : {{24{w_lane8[7]}}, w_lane8};
            2'd1:    w_load = r_unsigned ? {16'h0000, w_lane16} : {{16{w_lane16[15]}}, w_lane16};
            default: w_load = bus.mem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle control; stall is combinational so the core freezes in the request cycle.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_fault  = 1'b0;
        w_done   = 1'b0;
        w_stall  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_in) begin
                    w_stall = 1'b1;
                    if (w_misalign) begin
                        w_fault = 1'b1;
                        w_next  = ST_RESP;
                    end else begin
                        w_accept = 1'b1;
                        w_next   = ST_REQ;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                w_stall = 1'b1;
                if (bus.mem_ack) begin
                    w_done = 1'b1;
                    w_next = ST_RESP;
                end else if (w_timeout) begin
                    w_next = ST_RESP;
                end else begin
                    w_next = ST_REQ;
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Bus-side registers: captured at accept, held through REQ, request dropped on ack or timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0000_0000;
            r_off       <= 2'b00;
            r_size      <= 2'd0;
            r_unsigned  <= 1'b0;
            r_wait_cnt  <= '0;
        end else if (w_accept) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.MemWrite;
            r_mem_addr  <= {bus.address[AW-1:2], 2'b00};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
            r_off       <= w_off;
            r_size      <= w_size;
            r_unsigned  <= bus.funct3[2];
            r_wait_cnt  <= '0;
        end else if (r_state == ST_REQ) begin
            if (bus.mem_ack || w_timeout) begin
                r_mem_req  <= 1'b0;
                r_mem_we   <= 1'b0;
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
        end else begin
            r_mem_req <= 1'b0;
        end
    end

    // Core-side results: rdata updates only on entering RESP; errors force zero data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata   <= 32'h0000_0000;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_fault | w_timeout;
            if (w_fault || w_timeout) begin
                r_rdata <= 32'h0000_0000;
            end else if (w_done && !r_mem_we) begin
                r_rdata <= w_load;
            end else begin
                r_rdata <= r_rdata;
            end
        end
    end

    assign bus.stall     = w_stall;
    assign bus.rdata     = r_rdata;
    assign bus.bus_err   = r_bus_err;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_wdata = r_mem_wdata;
endmodule
